// File: rtl/mcu_block_sequencer.sv
// Reorders 4:2:0 MCUs (16x16 Y raster, then Cb and Cr 8x8) into six JPEG 8x8 blocks.
// Two ping-pong MCU banks let one MCU be received while the previous one is sent.
module mcu_block_sequencer #(
   parameter int DATA_WIDTH     = 8,
   parameter int MCUS_PER_FRAME = 4
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [1:0]            m_axis_tuser,
   output logic [2:0]            block_idx,
   output logic [15:0]           mcu_idx,
   output logic                  frame_done,
   output logic                  protocol_err
);

   typedef enum logic {ST_IDLE, ST_SEND} state_t;

   state_t r_state;
   state_t w_state_next;

   logic [DATA_WIDTH-1:0] r_mem [0:767];
   logic [1:0]  r_full;
   logic        r_wr_bank;
   logic        r_rd_bank;
   logic [8:0]  r_wr_ptr;
   logic [5:0]  r_rd_cnt;
   logic [2:0]  r_block_idx;
   logic [15:0] r_mcu_idx;
   logic        r_frame_done;
   logic        r_protocol_err;

   logic        w_s_hs;
   logic        w_commit;
   logic        w_early_last;
   logic        w_m_hs;
   logic        w_release;
   logic        w_mcu_wrap;
   logic [1:0]  w_full_next;
   logic [8:0]  w_rd_addr;
   logic [9:0]  w_wr_idx;
   logic [9:0]  w_rd_idx;
   logic        w_m_valid;

   // Input readiness also depends on aresetn so the port reads 0 while reset is held.
   assign s_axis_tready = aresetn & ~r_full[r_wr_bank];
   assign w_s_hs        = s_axis_tvalid & s_axis_tready;
   assign w_commit      = w_s_hs & (r_wr_ptr == 9'd383);
   assign w_early_last  = w_s_hs & s_axis_tlast & (r_wr_ptr != 9'd383);

   assign w_m_hs     = (r_state == ST_SEND) & m_axis_tready;
   assign w_release  = w_m_hs & (r_block_idx == 3'd5) & (r_rd_cnt == 6'd63);
   assign w_mcu_wrap = (r_mcu_idx == 16'(MCUS_PER_FRAME - 1));

   // Commit and release always target different banks, so both can apply at once.
   always_comb begin
      w_full_next = r_full;
      if (w_commit) begin
         w_full_next[r_wr_bank] = 1'b1;
      end
      if (w_release) begin
         w_full_next[r_rd_bank] = 1'b0;
      end
   end

   always_comb begin
      w_rd_addr = '0;
      if (r_block_idx < 3'd4) begin
         w_rd_addr = {1'b0, r_block_idx[1], r_rd_cnt[5:3], r_block_idx[0], r_rd_cnt[2:0]};
      end else if (r_block_idx == 3'd4) begin
         w_rd_addr = {3'b100, r_rd_cnt};
      end else begin
         w_rd_addr = {3'b101, r_rd_cnt};
      end
   end

   assign w_wr_idx = r_wr_bank ? (10'd384 + {1'b0, r_wr_ptr}) : {1'b0, r_wr_ptr};
   assign w_rd_idx = r_rd_bank ? (10'd384 + {1'b0, w_rd_addr}) : {1'b0, w_rd_addr};

   always_ff @(posedge aclk) begin
      if (w_s_hs) begin
         r_mem[w_wr_idx] <= s_axis_tdata;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Looking at w_full_next lets a same-cycle commit start the read side without a bubble.
   always_comb begin
      w_state_next = r_state;
      w_m_valid    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_full_next[r_rd_bank]) begin
               w_state_next = ST_SEND;
            end
         end
         ST_SEND: begin
            w_m_valid = 1'b1;
            if (w_release) begin
               w_state_next = w_full_next[~r_rd_bank] ? ST_SEND : ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_full         <= 2'b00;
         r_wr_bank      <= 1'b0;
         r_rd_bank      <= 1'b0;
         r_wr_ptr       <= '0;
         r_rd_cnt       <= '0;
         r_block_idx    <= '0;
         r_mcu_idx      <= '0;
         r_frame_done   <= 1'b0;
         r_protocol_err <= 1'b0;
      end else begin
         r_full       <= w_full_next;
         r_frame_done <= 1'b0;
         if (w_s_hs) begin
            if (w_commit) begin
               r_wr_bank <= ~r_wr_bank;
               r_wr_ptr  <= '0;
               if (!s_axis_tlast) begin
                  r_protocol_err <= 1'b1;
               end
            end else if (w_early_last) begin
               r_wr_ptr       <= '0;
               r_protocol_err <= 1'b1;
            end else begin
               r_wr_ptr <= r_wr_ptr + 9'd1;
            end
         end
         if (w_m_hs) begin
            if (r_rd_cnt == 6'd63) begin
               r_rd_cnt <= '0;
               if (r_block_idx == 3'd5) begin
                  r_block_idx  <= '0;
                  r_rd_bank    <= ~r_rd_bank;
                  r_mcu_idx    <= w_mcu_wrap ? 16'd0 : r_mcu_idx + 16'd1;
                  r_frame_done <= w_mcu_wrap;
               end else begin
                  r_block_idx <= r_block_idx + 3'd1;
               end
            end else begin
               r_rd_cnt <= r_rd_cnt + 6'd1;
            end
         end
      end
   end

   assign m_axis_tdata  = r_mem[w_rd_idx];
   assign m_axis_tvalid = w_m_valid;
   assign m_axis_tlast  = (r_rd_cnt == 6'd63);
   assign m_axis_tuser  = (r_block_idx == 3'd4) ? 2'd1 :
                          (r_block_idx == 3'd5) ? 2'd2 : 2'd0;
   assign block_idx     = r_block_idx;
   assign mcu_idx       = r_mcu_idx;
   assign frame_done    = r_frame_done;
   assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_mcu_block_sequencer.sv
// Self-checking bench: MCUs are modelled as 16x16/8x8 pictures and cut into JPEG
// blocks by quadrant; every output beat is compared against that expected stream.
module tb_mcu_block_sequencer;

   localparam int DW  = 8;
   localparam int MPF = 2;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic [1:0]    m_axis_tuser;
   logic [2:0]    block_idx;
   logic [15:0]   mcu_idx;
   logic          frame_done;
   logic          protocol_err;

   always #5 aclk = ~aclk;

   mcu_block_sequencer #(.DATA_WIDTH(DW), .MCUS_PER_FRAME(MPF)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .m_axis_tuser(m_axis_tuser), .block_idx(block_idx), .mcu_idx(mcu_idx),
      .frame_done(frame_done), .protocol_err(protocol_err)
   );

   typedef struct packed {
      logic [7:0]  d;
      logic [1:0]  u;
      logic        l;
      logic [2:0]  b;
      logic [15:0] m;
   } beat_t;

   beat_t      exp_q[$];
   logic [7:0] mcu_buf [384];
   int   total = 0;
   int   bad = 0;
   int   model_mcu = 0;
   int   hs_cnt = 0;
   int   cyc = 0;
   int   first_hs_cyc = 0;
   int   last_hs_cyc = 0;
   int   fd_cnt = 0;
   logic fd_pend = 1'b0;
   bit   rnd_ready = 0;
   bit   rnd_gap = 0;
   bit   all_done = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic finish_tb();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // Expected stream: Y blocks are the four 8x8 quadrants (TL, TR, BL, BR), then Cb, Cr.
   task automatic push_mcu();
      for (int b = 0; b < 6; b++) begin
         for (int k = 0; k < 64; k++) begin
            int src;
            beat_t e;
            if (b < 4) src = ((b / 2) * 8 + k / 8) * 16 + (b % 2) * 8 + k % 8;
            else       src = 256 + (b - 4) * 64 + k;
            e.d = mcu_buf[src];
            e.u = (b < 4) ? 2'd0 : 2'(b - 3);
            e.l = (k == 63);
            e.b = 3'(b);
            e.m = 16'(model_mcu);
            exp_q.push_back(e);
         end
      end
      model_mcu = (model_mcu + 1) % MPF;
   endtask

   task automatic fill_random();
      for (int i = 0; i < 384; i++) mcu_buf[i] = 8'($urandom);
   endtask

   // Sends mcu_buf[0..n-1]; tlast is raised on sample tlast_at (-1 = never).
   task automatic send(input int n, input int tlast_at);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         if (rnd_gap && ($urandom_range(0, 3) == 0)) begin
            s_axis_tvalid = 1'b0;
            @(posedge aclk); #1;
         end
         s_axis_tdata  = mcu_buf[i];
         s_axis_tvalid = 1'b1;
         s_axis_tlast  = (i == tlast_at);
         forever begin
            @(negedge aclk);
            if (s_axis_tready) break;
            t++;
            if (t > 5000) begin
               check("in_ready_timeout", {31'd0, s_axis_tready}, 32'd1);
               finish_tb();
            end
         end
         @(posedge aclk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while (exp_q.size() != 0) begin
         @(negedge aclk);
         t++;
         if (t > 10000) begin
            check("drain_timeout", exp_q.size(), 32'd0);
            finish_tb();
         end
      end
      repeat (3) @(posedge aclk);
      #1;
      check("idle_after_drain", {31'd0, m_axis_tvalid}, 32'd0);
   endtask

   task automatic do_reset();
      aresetn       = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      exp_q.delete();
      model_mcu = 0;
      @(posedge aclk); #1;
      @(posedge aclk); #1;
      check("rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      check("rst_in_ready", {31'd0, s_axis_tready}, 32'd0);
      check("rst_frame_done", {31'd0, frame_done}, 32'd0);
      check("rst_protocol_err", {31'd0, protocol_err}, 32'd0);
      check("rst_block_idx", {29'd0, block_idx}, 32'd0);
      check("rst_mcu_idx", {16'd0, mcu_idx}, 32'd0);
      aresetn = 1'b1;
      #1;
      check("in_ready_after_rst", {31'd0, s_axis_tready}, 32'd1);
   endtask

   initial begin
      forever begin
         @(posedge aclk); #1;
         m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor: each beat is checked at the handshake, and held beats are checked too.
   always @(negedge aclk) begin
      beat_t obs;
      cyc++;
      if (!aresetn) begin
         fd_pend = 1'b0;
         hs_cnt  = 0;
      end else begin
         check("frame_done", {31'd0, frame_done}, {31'd0, fd_pend});
         if (frame_done) fd_cnt++;
         fd_pend = 1'b0;
         if (m_axis_tvalid) begin
            obs = {m_axis_tdata, m_axis_tuser, m_axis_tlast, block_idx, mcu_idx};
            if (exp_q.size() == 0) begin
               check("spurious_valid", {31'd0, m_axis_tvalid}, 32'd0);
            end else if (m_axis_tready) begin
               check("out_beat", {2'd0, obs}, {2'd0, exp_q.pop_front()});
               hs_cnt++;
               if (hs_cnt == 1) first_hs_cyc = cyc;
               last_hs_cyc = cyc;
               if (hs_cnt % (384 * MPF) == 0) fd_pend = 1'b1;
            end else begin
               check("stall_hold", {2'd0, obs}, {2'd0, exp_q[0]});
            end
         end
      end
   end

   initial begin
      #2000000;
      check("watchdog", {31'd0, all_done}, 32'd1);
      finish_tb();
   end

   initial begin
      int t;
      // Fixed pattern MCU, downstream always ready.
      do_reset();
      for (int i = 0; i < 256; i++) mcu_buf[i] = 8'(i);
      for (int k = 0; k < 64; k++) begin
         mcu_buf[256 + k] = 8'(8'h80 + k);
         mcu_buf[320 + k] = 8'(8'hC0 + k);
      end
      push_mcu();
      send(384, 383);
      check("first_out_latency", {31'd0, m_axis_tvalid}, 32'd1);
      wait_drain();
      check("err_clean", {31'd0, protocol_err}, 32'd0);
      $display("step single_mcu beats=%0d", hs_cnt);

      // Three back-to-back MCUs: gapless output and one frame_done.
      do_reset();
      fd_cnt = 0;
      for (int m = 0; m < 3; m++) begin
         fill_random();
         push_mcu();
         send(384, 383);
      end
      wait_drain();
      check("b2b_count", hs_cnt, 32'd1152);
      check("b2b_no_gaps", last_hs_cyc - first_hs_cyc, 32'd1151);
      check("b2b_frame_pulses", fd_cnt, 32'd1);
      $display("step back_to_back beats=%0d span=%0d", hs_cnt, last_hs_cyc - first_hs_cyc);

      // Random downstream stalls with two MCUs in flight.
      do_reset();
      rnd_ready = 1;
      fill_random();
      push_mcu();
      send(384, 383);
      fill_random();
      push_mcu();
      send(384, 383);
      check("both_full_backpressure", {31'd0, s_axis_tready}, {31'd0, (hs_cnt >= 384)});
      wait_drain();
      rnd_ready = 0;
      $display("step random_ready beats=%0d", hs_cnt);

      // Early tlast discards the partial MCU.
      fill_random();
      send(101, 100);
      check("early_tlast_err", {31'd0, protocol_err}, 32'd1);
      t = hs_cnt;
      fill_random();
      push_mcu();
      send(384, 383);
      wait_drain();
      check("early_tlast_out_count", hs_cnt - t, 32'd384);
      $display("step early_tlast beats=%0d", hs_cnt - t);

      // Missing tlast still commits; input gaps exercised here.
      do_reset();
      rnd_gap = 1;
      fill_random();
      push_mcu();
      send(384, -1);
      check("missing_tlast_err", {31'd0, protocol_err}, 32'd1);
      fill_random();
      push_mcu();
      send(384, 383);
      wait_drain();
      rnd_gap = 0;
      check("missing_tlast_count", hs_cnt, 32'd768);
      $display("step missing_tlast beats=%0d", hs_cnt);

      // Reset in the middle of block 2.
      do_reset();
      fill_random();
      push_mcu();
      send(384, 383);
      t = 0;
      while (!(m_axis_tvalid && block_idx == 3'd2)) begin
         @(negedge aclk);
         t++;
         if (t > 3000) begin
            check("reach_block2_timeout", {29'd0, block_idx}, 32'd2);
            finish_tb();
         end
      end
      @(posedge aclk); #1;
      aresetn = 1'b0;
      exp_q.delete();
      model_mcu = 0;
      #1;
      check("midsend_rst_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      #1;
      check("midsend_rst_mcu_idx", {16'd0, mcu_idx}, 32'd0);
      check("midsend_rst_idle", {31'd0, m_axis_tvalid}, 32'd0);
      fill_random();
      push_mcu();
      send(384, 383);
      wait_drain();
      check("midsend_rst_count", hs_cnt, 32'd384);
      $display("step midsend_reset beats=%0d", hs_cnt);

      all_done = 1;
      finish_tb();
   end

endmodule

// File: doc/mcu_block_sequencer.md
Name: mcu_block_sequencer

Overview:
- Sits between the chroma downsampling stage and the DCT stage of the JPEG encoder.
- Accepts one 384-sample 4:2:0 MCU per AXIS packet, in this order:
  - 256 Y samples, 16x16 raster, index = row*16 + col.
  - 64 Cb samples, 8x8 raster.
  - 64 Cr samples, 8x8 raster.
- Re-emits each MCU as six 8x8 blocks in JPEG order Y0, Y1, Y2, Y3, Cb, Cr, each block raster order, each closed by tlast.
- Ping-pong MCU buffers let the next MCU be received while the current one is sent; block tags and frame counting are provided for the entropy stage.

Parameters:
- DATA_WIDTH, 8, sample width.
- MCUS_PER_FRAME, 4, MCUs per frame; frame counter wraps here. Legal range 1..65535.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  DATA_WIDTH  MCU sample.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  marks sample 383 of the MCU.
- m_axis_tdata  out  DATA_WIDTH  block sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  high on sample 63 of every block.
- m_axis_tuser  out  2  component: 0=Y, 1=Cb, 2=Cr.
- block_idx  out  3  block number within MCU, 0..5.
- mcu_idx  out  16  index of MCU currently being sent, 0..MCUS_PER_FRAME-1.
- frame_done  out  1  one-cycle pulse after the last handshake of the last MCU in a frame.
- protocol_err  out  1  sticky; cleared only by reset.

Behaviour:
- Reset (asynchronous, aresetn low):
  - Outputs: m_axis_tvalid=0, s_axis_tready=0, frame_done=0, protocol_err=0, block_idx=0, mcu_idx=0.
  - Both banks empty, write bank=0, read bank=0, pointers 0.
  - Buffer contents are not reset.
  - Reset asserted mid-MCU discards all partial data.
- Write side:
  - s_axis_tready=1 whenever the write bank is empty, including the first cycle after reset release.
  - Each handshake stores the sample at wr_ptr (0..383), then increments wr_ptr.
  - Handshake with wr_ptr==383:
    - Bank marked full, write bank toggles, wr_ptr=0.
    - If s_axis_tlast=0 there, set protocol_err; the bank is still committed.
  - Early tlast (tlast=1 with wr_ptr<383): set protocol_err, discard the bank (not committed), wr_ptr=0, same bank reused.
  - When both banks are full, s_axis_tready=0.
- Read side FSM:
  - IDLE: wait for the read bank to be full, then go to SEND with rd_cnt=0, block_idx=0. m_axis_tvalid rises the cycle after the committing handshake, so minimum latency is 1 cycle.
  - SEND:
    - m_axis_tvalid=1.
    - Address generation, with r=rd_cnt[5:3], c=rd_cnt[2:0]:
      - block b<4: addr = ((b>>1)*8 + r)*16 + (b&1)*8 + c.
      - b=4: addr = 256 + rd_cnt.
      - b=5: addr = 320 + rd_cnt.
    - m_axis_tdata is valid combinationally from the buffer in the same cycle as tvalid.
    - Outputs held stable while tready=0.
    - m_axis_tuser: 0 for b<=3, 1 for b=4, 2 for b=5.
    - m_axis_tlast=1 when rd_cnt==63.
    - On handshake: rd_cnt++. At rd_cnt==63, rd_cnt=0 and block_idx++.
    - Handshake at block 5, rd_cnt 63:
      - Release the bank (empty) and toggle the read bank.
      - mcu_idx increments, wrapping to 0 after MCUS_PER_FRAME-1; on the wrap, pulse frame_done next cycle.
      - If the other bank is already full, go directly to SEND (no bubble); else go to IDLE.
- Simultaneous events:
  - A bank release and a commit to the other bank in the same cycle are both honoured.
  - A released bank is writable the next cycle.
- Sustained throughput: 384 samples per MCU per side, no idle cycles between MCUs when both sides stream.

Test Plan:
- Single MCU with Y[i]=i[7:0], Cb=0x80+k, Cr=0xC0+k (k=0..63), tready=1:
  - Block0 = Y rows 0..7, cols 0..7 (first samples 0,1,..7, then 16..23).
  - Block1 starts 8; Block2 starts 128 (0x80); Block3 starts 136 (0x88).
  - Cb block 0x80..0xBF with tuser=1; Cr block 0xC0..0xFF with tuser=2.
  - tlast on every 64th output; tvalid the cycle after the input tlast.
- Back-to-back 3 MCUs, tready=1, MCUS_PER_FRAME=2:
  - 1152 outputs with no gaps once started.
  - mcu_idx sequence 0,1,0; frame_done pulses once, after output 767.
- Random tready (50%) while two MCUs stream in:
  - s_axis_tready drops after the second MCU commits while the first is unsent.
  - Output order and data are exact; data is stable while stalled.
- Early tlast at sample 100, then a full MCU:
  - protocol_err=1; only the full MCU is emitted (384 outputs).
- Missing tlast at sample 383:
  - protocol_err=1; the MCU is still emitted intact; the next sample starts a new MCU.
- aresetn pulsed low mid-SEND (block 2):
  - tvalid=0 immediately; after release only newly sent MCUs appear, mcu_idx=0.
